// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: icache read port, dcache read/write
// ports and the shared memory-side read/write channels.
// The slave modport is the arbiter's view; master is the environment
// (caches plus memory) driving the other side.
interface mem_bus_arbiter_if;
  // icache read port
  logic        i_arvalid;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic        i_arready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_rlast;
  logic        i_rready;
  // dcache read port
  logic        d_arvalid;
  logic [31:0] d_araddr;
  logic [7:0]  d_arlen;
  logic        d_arready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_rlast;
  logic        d_rready;
  // dcache write port
  logic        d_awvalid;
  logic [31:0] d_awaddr;
  logic [7:0]  d_awlen;
  logic        d_awready;
  logic        d_wvalid;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wready;
  logic        d_bvalid;
  logic        d_bready;
  // memory read channels
  logic        m_arvalid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic        m_rready;
  // memory write channels
  logic        m_awvalid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awready;
  logic        m_wvalid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wready;
  logic        m_bvalid;
  logic        m_bready;

  modport slave (
    input  i_arvalid, i_araddr, i_arlen, i_rready,
    input  d_arvalid, d_araddr, d_arlen, d_rready,
    input  d_awvalid, d_awaddr, d_awlen, d_wvalid, d_wdata, d_wstrb, d_bready,
    input  m_arready, m_rvalid, m_rdata, m_rlast,
    input  m_awready, m_wready, m_bvalid,
    output i_arready, i_rvalid, i_rdata, i_rlast,
    output d_arready, d_rvalid, d_rdata, d_rlast,
    output d_awready, d_wready, d_bvalid,
    output m_arvalid, m_araddr, m_arlen, m_rready,
    output m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
  );

  modport master (
    output i_arvalid, i_araddr, i_arlen, i_rready,
    output d_arvalid, d_araddr, d_arlen, d_rready,
    output d_awvalid, d_awaddr, d_awlen, d_wvalid, d_wdata, d_wstrb, d_bready,
    output m_arready, m_rvalid, m_rdata, m_rlast,
    output m_awready, m_wready, m_bvalid,
    input  i_arready, i_rvalid, i_rdata, i_rlast,
    input  d_arready, d_rvalid, d_rdata, d_rlast,
    input  d_awready, d_wready, d_bvalid,
    input  m_arvalid, m_araddr, m_arlen, m_rready,
    input  m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one memory port between an icache (read only) and a
// dcache (read + write). Reads: one burst outstanding, alternating grant
// on ties. Writes: independent FSM running alongside the read FSM; a
// dcache read that hits the 16-byte line of an in-flight write is held
// back until the write response completes.
module mem_bus_arbiter (
  input logic              clk,
  input logic              rstn,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  // read side state
  rd_state_t   r_rd_state;
  logic        r_gnt_i;      // 1: current burst belongs to icache
  logic        r_last_i;     // 1: last issued burst was icache
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;

  // write side state
  wr_state_t   r_wr_state;
  logic [31:0] r_awaddr;
  logic [7:0]  r_awlen;
  logic [7:0]  r_wcnt;

  // combinational helpers
  logic w_d_hazard;
  logic w_i_elig;
  logic w_d_elig;
  logic w_pick_i;
  logic w_m_rready;
  logic w_rd_beat;
  logic w_wr_beat;
  logic w_wlast;

  // Eligibility and grant choice: dcache reads hitting the pending write line are masked out.
  always_comb begin
    w_d_hazard = 1'b0;
    if (r_wr_state != W_IDLE) begin
      w_d_hazard = (bus.d_araddr[31:4] == r_awaddr[31:4]);
    end else begin
      w_d_hazard = 1'b0;
    end
    w_i_elig  = bus.i_arvalid;
    w_d_elig  = bus.d_arvalid & ~w_d_hazard;
    // On a tie give the grant to whoever did not get it last time.
    w_pick_i  = w_i_elig & (~w_d_elig | ~r_last_i);
    w_wlast   = (r_wcnt == r_awlen);
    w_wr_beat = (r_wr_state == W_DATA) & bus.d_wvalid & bus.m_wready;
    w_rd_beat = (r_rd_state == R_DATA) & bus.m_rvalid & w_m_rready;
  end

  // Read FSM: arbitrate in R_IDLE, issue address in R_ADDR, stream beats in R_DATA.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_state <= R_IDLE;
      r_gnt_i    <= 1'b0;
      r_last_i   <= 1'b1;
      r_araddr   <= 32'h0000_0000;
      r_arlen    <= 8'h00;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_i_elig || w_d_elig) begin
            r_gnt_i    <= w_pick_i;
            r_araddr   <= w_pick_i ? bus.i_araddr : bus.d_araddr;
            r_arlen    <= w_pick_i ? bus.i_arlen  : bus.d_arlen;
            r_rd_state <= R_ADDR;
          end else begin
            r_rd_state <= R_IDLE;
          end
        end
        R_ADDR: begin
          if (bus.m_arready) begin
            r_last_i   <= r_gnt_i;
            r_rd_state <= R_DATA;
          end else begin
            r_rd_state <= R_ADDR;
          end
        end
        R_DATA: begin
          if (w_rd_beat && bus.m_rlast) begin
            r_rd_state <= R_IDLE;
          end else begin
            r_rd_state <= R_DATA;
          end
        end
        default: begin
          r_rd_state <= R_IDLE;
        end
      endcase
    end
  end

  // Read-side outputs: address from latched request, data routed only to the granted port.
  always_comb begin
    bus.m_arvalid = 1'b0;
    bus.m_araddr  = 32'h0000_0000;
    bus.m_arlen   = 8'h00;
    bus.i_arready = 1'b0;
    bus.d_arready = 1'b0;
    w_m_rready    = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = 32'h0000_0000;
    bus.i_rlast   = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = 32'h0000_0000;
    bus.d_rlast   = 1'b0;
    case (r_rd_state)
      R_ADDR: begin
        bus.m_arvalid = 1'b1;
        bus.m_araddr  = r_araddr;
        bus.m_arlen   = r_arlen;
        if (r_gnt_i) begin
          bus.i_arready = bus.m_arready;
        end else begin
          bus.d_arready = bus.m_arready;
        end
      end
      R_DATA: begin
        if (r_gnt_i) begin
          w_m_rready   = bus.i_rready;
          bus.i_rvalid = bus.m_rvalid;
          bus.i_rdata  = bus.m_rdata;
          bus.i_rlast  = bus.m_rlast;
        end else begin
          w_m_rready   = bus.d_rready;
          bus.d_rvalid = bus.m_rvalid;
          bus.d_rdata  = bus.m_rdata;
          bus.d_rlast  = bus.m_rlast;
        end
      end
      default: begin
        bus.m_arvalid = 1'b0;
      end
    endcase
    bus.m_rready = w_m_rready;
  end

  // Write FSM: latch request, issue address, count beats up to the latched length, await response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_state <= W_IDLE;
      r_awaddr   <= 32'h0000_0000;
      r_awlen    <= 8'h00;
      r_wcnt     <= 8'h00;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (bus.d_awvalid) begin
            r_awaddr   <= bus.d_awaddr;
            r_awlen    <= bus.d_awlen;
            r_wcnt     <= 8'h00;
            r_wr_state <= W_ADDR;
          end else begin
            r_wr_state <= W_IDLE;
          end
        end
        W_ADDR: begin
          if (bus.m_awready) begin
            r_wr_state <= W_DATA;
          end else begin
            r_wr_state <= W_ADDR;
          end
        end
        W_DATA: begin
          if (w_wr_beat && w_wlast) begin
            r_wr_state <= W_RESP;
          end else if (w_wr_beat) begin
            r_wcnt     <= r_wcnt + 8'd1;
          end else begin
            r_wr_state <= W_DATA;
          end
        end
        W_RESP: begin
          if (bus.m_bvalid && bus.d_bready) begin
            r_wr_state <= W_IDLE;
          end else begin
            r_wr_state <= W_RESP;
          end
        end
        default: begin
          r_wr_state <= W_IDLE;
        end
      endcase
    end
  end

  // Write-side outputs: pass-through only in the phase that owns each channel.
  always_comb begin
    bus.m_awvalid = 1'b0;
    bus.m_awaddr  = 32'h0000_0000;
    bus.m_awlen   = 8'h00;
    bus.d_awready = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.m_wdata   = 32'h0000_0000;
    bus.m_wstrb   = 4'h0;
    bus.m_wlast   = 1'b0;
    bus.d_wready  = 1'b0;
    bus.d_bvalid  = 1'b0;
    bus.m_bready  = 1'b0;
    case (r_wr_state)
      W_ADDR: begin
        bus.m_awvalid = 1'b1;
        bus.m_awaddr  = r_awaddr;
        bus.m_awlen   = r_awlen;
        bus.d_awready = bus.m_awready;
      end
      W_DATA: begin
        bus.m_wvalid = bus.d_wvalid;
        bus.m_wdata  = bus.d_wdata;
        bus.m_wstrb  = bus.d_wstrb;
        bus.m_wlast  = w_wlast;
        bus.d_wready = bus.m_wready;
      end
      W_RESP: begin
        bus.d_bvalid = bus.m_bvalid;
        bus.m_bready = bus.d_bready;
      end
      default: begin
        bus.m_awvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters: none; address 32 b, data 32 b, burst length 8 b (AXI arlen/awlen encoding, beats = len+1).
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 i_arvalid/i_araddr/i_arlen  in  1/32/8  icache read request; held stable until i_arready.
REQ-005 i_arready  out  1  icache address accepted.
REQ-006 i_rvalid/i_rdata/i_rlast  out  1/32/1  icache read data; i_rready  in  1  icache data accept.
REQ-007 d_arvalid/d_araddr/d_arlen  in  1/32/8  dcache read request; d_arready  out  1.
REQ-008 d_rvalid/d_rdata/d_rlast  out  1/32/1  dcache read data; d_rready  in  1.
REQ-009 d_awvalid/d_awaddr/d_awlen  in  1/32/8  dcache write request; d_awready  out  1.
REQ-010 d_wvalid/d_wdata/d_wstrb  in  1/32/4  dcache write beat; d_wready  out  1.
REQ-011 d_bvalid  out  1  write complete; d_bready  in  1.
REQ-012 m_arvalid/m_araddr/m_arlen  out  1/32/8; m_arready  in  1  memory read address channel.
REQ-013 m_rvalid/m_rdata/m_rlast  in  1/32/1; m_rready  out  1  memory read data channel.
REQ-014 m_awvalid/m_awaddr/m_awlen  out  1/32/8; m_awready  in  1.
REQ-015 m_wvalid/m_wdata/m_wstrb/m_wlast  out  1/32/4/1; m_wready  in  1.
REQ-016 m_bvalid  in  1; m_bready  out  1  memory write response.

Function
REQ-017 Read FSM states R_IDLE, R_ADDR, R_DATA; one read burst outstanding at a time.
REQ-018 R_IDLE: only one pending requester -> grant it; both pending -> grant the one not granted last (last_grant flop); latch addr/len/grant; next R_ADDR; nothing pending -> stay.
REQ-019 Grant decision and latching take one cycle; m_arvalid asserts the cycle after the request is first seen in R_IDLE.
REQ-020 R_ADDR: m_arvalid=1 with latched addr/len; granted x_arready = m_arready (combinational); on m_arready -> R_DATA, update last_grant.
REQ-021 R_DATA: m_rdata/m_rvalid/m_rlast routed only to granted port; m_rready = granted x_rready; non-granted rvalid = 0.
REQ-022 R_DATA: beat with m_rvalid & m_rready & m_rlast -> R_IDLE; new grant possible the next cycle.
REQ-023 Write FSM states W_IDLE, W_ADDR, W_DATA, W_RESP; runs concurrently with read FSM.
REQ-024 W_IDLE: d_awvalid -> latch addr/len, clear beat counter, W_ADDR; W_ADDR: m_awvalid=1, d_awready = m_awready, handshake -> W_DATA.
REQ-025 W_DATA: m_wvalid = d_wvalid, d_wready = m_wready, data/strb pass through; counter increments per handshake; m_wlast = (counter == latched len); last handshake -> W_RESP.
REQ-026 W_RESP: d_bvalid = m_bvalid, m_bready = d_bready; handshake -> W_IDLE.
REQ-027 Hazard: while write FSM != W_IDLE, dcache read with d_araddr[31:4] == latched awaddr[31:4] is not granted; icache may still be granted (last_grant rule applies among eligible only).
REQ-028 Counter is 8 b, never wraps: bursts beyond len+1 beats do not occur (d_wlast from cache ignored).
REQ-029 Requester dropping arvalid before arready: undefined; latched request still issued.

Reset
REQ-030 rstn low: read FSM R_IDLE, write FSM W_IDLE, last_grant = icache (dcache wins first tie), counter 0.
REQ-031 During reset all outputs 0: valids, readies, addr, len, data, wlast; mid-burst reset abandons the transfer with no completion signalled.

Verification
REQ-032 i_arvalid, i_araddr=0x1C000010, i_arlen=3, m_arready=1 -> m_araddr=0x1C000010 one cycle after request, 4 beats to icache, i_rlast on 4th, R_IDLE after.
REQ-033 i_arvalid and d_arvalid same cycle after reset -> dcache granted first; icache issued after dcache rlast; repeat tie -> dcache again (alternation).
REQ-034 Write awaddr=0x00001000 len=3 pending, d_araddr=0x00001008 -> read held until d_bvalid&d_bready; icache read 0x2000 proceeds meanwhile.
REQ-035 Write len=3, m_wready toggling 1/0 -> exactly 4 beats forwarded, m_wlast only on 4th, d_bvalid mirrors m_bvalid.
REQ-036 rstn low during R_DATA beat 2 -> all outputs 0 immediately; after release new request served normally from R_IDLE.
